// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared FSM encoding, interrupt codes and mcause field widths
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] IRQ_MSI = 5'd3;
  localparam logic [CODE_W-1:0] IRQ_MTI = 5'd7;
  localparam logic [CODE_W-1:0] IRQ_MEI = 5'd11;

  function automatic logic is_std_irq(input int idx);
    return (idx == int'(IRQ_MSI)) || (idx == int'(IRQ_MTI)) || (idx == int'(IRQ_MEI));
  endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// rtl/irq_prio_sel.sv - masked fixed-priority interrupt encoder (MEI > MSI > MTI > others high-to-low)
module irq_prio_sel
  import trap_pkg::*;
#(
  parameter int NUM_IRQ = 16
) (
  input  logic [NUM_IRQ-1:0] irq_pend,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               gie,
  output logic               irq_vld,
  output logic [CODE_W-1:0]  irq_code
);

  logic [NUM_IRQ-1:0] masked;

  assign masked = irq_pend & irq_en & {NUM_IRQ{gie}};

  always_comb begin
    irq_vld  = |masked;
    irq_code = '0;
    // Later assignments win: ascending scan leaves the highest non-standard line,
    // then the standard lines override in rising priority order.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (masked[i] && !is_std_irq(i)) irq_code = CODE_W'(i);
    end
    if (masked[IRQ_MTI]) irq_code = IRQ_MTI;
    if (masked[IRQ_MSI]) irq_code = IRQ_MSI;
    if (masked[IRQ_MEI]) irq_code = IRQ_MEI;
  end

endmodule

// File: rtl/trap_flush_ctrl.sv
// rtl/trap_flush_ctrl.sv - commit-point trap/mret/mispredict arbiter and fetch flush handshake
// Optional debug halt FSM enabled by defining TRAP_FLUSH_DEBUG_EN.
module trap_flush_ctrl
  import trap_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter int              NUM_IRQ = 16,
  parameter logic [XLEN-1:0] RST_PC  = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmt_vld_i,
  output logic               cmt_rdy_o,
  input  logic [XLEN-1:0]    cmt_pc_i,
  input  logic [XLEN-1:0]    cmt_npc_i,
  input  logic               bjp_mispred_i,
  input  logic [XLEN-1:0]    bjp_fix_addr_i,
  input  logic               mret_i,
  input  logic               excp_vld_i,
  input  logic [4:0]         excp_cause_i,
  input  logic [XLEN-1:0]    excp_tval_i,
  input  logic [NUM_IRQ-1:0] irq_pend_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               mstatus_mie_i,
  input  logic [XLEN-1:0]    mtvec_i,
  input  logic [XLEN-1:0]    mepc_i,
  output logic               csr_trap_o,
  output logic               csr_mret_o,
  output logic [XLEN-1:0]    csr_epc_o,
  output logic [XLEN-1:0]    csr_cause_o,
  output logic [XLEN-1:0]    csr_tval_o,
  output logic               flush_early_o,
  output logic               flush_vld_o,
  output logic [XLEN-1:0]    flush_addr_o,
  input  logic               flush_rdy_i,
  input  logic               halt_req_i,
  input  logic               resume_req_i,
  input  logic               pipe_empty_i,
  output logic               halted_o,
  output logic [XLEN-1:0]    dpc_o
);

  localparam logic [XLEN-1:0] unused_rst_pc = RST_PC;

  state_e              state_q;
  logic                rdy_q;
  logic                flush_vld_q;
  logic [XLEN-1:0]     flush_addr_q;
  logic [XLEN-1:0]     last_npc_q;
  logic                halted_q;
  logic [XLEN-1:0]     dpc_q;

  logic                fire;
  logic                in_idle;
  logic                irq_vld;
  logic [CODE_W-1:0]   irq_code;
  logic                ev_excp, ev_irq, ev_mret, ev_misp, ev_trap, ev_any;
  logic [CODE_W-1:0]   trap_code;
  logic [XLEN-1:0]     trap_base;
  logic [XLEN-1:0]     target;
  logic [XLEN-1:0]     trap_epc;
  logic                halt_go, drain_done, resume_go;

`ifdef TRAP_FLUSH_DEBUG_EN
  assign halt_go    = halt_req_i;
  assign drain_done = pipe_empty_i;
  assign resume_go  = resume_req_i;
`else
  logic unused_dbg;
  assign unused_dbg = ^{halt_req_i, resume_req_i, pipe_empty_i};
  assign halt_go    = 1'b0;
  assign drain_done = 1'b0;
  assign resume_go  = 1'b0;
`endif

  irq_prio_sel #(.NUM_IRQ(NUM_IRQ)) u_irq_prio_sel (
    .irq_pend (irq_pend_i),
    .irq_en   (irq_en_i),
    .gie      (mstatus_mie_i),
    .irq_vld  (irq_vld),
    .irq_code (irq_code)
  );

  // rdy_q is low for the partial cycle after reset release, which also keeps
  // interrupts from strobing the CSRs while reset is held.
  assign in_idle = (state_q == ST_IDLE) & rdy_q;
  assign fire    = cmt_vld_i & rdy_q;

  assign ev_excp = in_idle & fire & excp_vld_i;
  assign ev_irq  = in_idle & irq_vld & ~ev_excp;
  assign ev_mret = in_idle & fire & mret_i & ~ev_excp & ~ev_irq;
  assign ev_misp = in_idle & fire & bjp_mispred_i & ~ev_excp & ~ev_irq;
  assign ev_trap = ev_excp | ev_irq;
  assign ev_any  = ev_trap | ev_mret | ev_misp;

  assign trap_code = ev_irq ? irq_code : excp_cause_i;
  assign trap_epc  = ev_excp ? cmt_pc_i : (fire ? cmt_npc_i : last_npc_q);

  always_comb begin
    trap_base = {mtvec_i[XLEN-1:2], 2'b00};
    if (ev_irq && (mtvec_i[1:0] == 2'b01))
      trap_base = trap_base + {{(XLEN-CODE_W-2){1'b0}}, irq_code, 2'b00};
    if (ev_trap)      target = trap_base;
    else if (ev_mret) target = mepc_i;
    else              target = bjp_fix_addr_i;
  end

  assign csr_trap_o    = ev_trap;
  assign csr_mret_o    = ev_mret;
  assign csr_epc_o     = ev_trap ? trap_epc : '0;
  assign csr_cause_o   = ev_trap ? {ev_irq, {(XLEN-1-CODE_W){1'b0}}, trap_code} : '0;
  assign csr_tval_o    = ev_excp ? excp_tval_i : '0;
  assign flush_early_o = ev_any;

  assign cmt_rdy_o    = rdy_q;
  assign flush_vld_o  = flush_vld_q;
  assign flush_addr_o = flush_addr_q;
  assign halted_o     = halted_q;
  assign dpc_o        = dpc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rdy_q        <= 1'b0;
      flush_vld_q  <= 1'b0;
      flush_addr_q <= '0;
      last_npc_q   <= '0;
      halted_q     <= 1'b0;
      dpc_q        <= '0;
    end else begin
      if (fire) last_npc_q <= cmt_npc_i;
      case (state_q)
        ST_IDLE: begin
          if (ev_any) begin
            state_q      <= ST_FLUSH;
            rdy_q        <= 1'b0;
            flush_vld_q  <= 1'b1;
            flush_addr_q <= target;
          end else if (halt_go) begin
            state_q <= ST_DRAIN;
            rdy_q   <= 1'b0;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_vld_q && flush_rdy_i) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b1;
            flush_vld_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
            dpc_q    <= last_npc_q;
          end
        end
        ST_HALTED: begin
          if (resume_go) begin
            state_q      <= ST_FLUSH;
            halted_q     <= 1'b0;
            flush_vld_q  <= 1'b1;
            flush_addr_q <= dpc_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_flush_ctrl.sv
// tb/tb_trap_flush_ctrl.sv - directed vector bench for trap_flush_ctrl
module tb_trap_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmt_vld_i, cmt_rdy_o;
  logic [31:0] cmt_pc_i, cmt_npc_i;
  logic        bjp_mispred_i;
  logic [31:0] bjp_fix_addr_i;
  logic        mret_i, excp_vld_i;
  logic [4:0]  excp_cause_i;
  logic [31:0] excp_tval_i;
  logic [15:0] irq_pend_i, irq_en_i;
  logic        mstatus_mie_i;
  logic [31:0] mtvec_i, mepc_i;
  logic        csr_trap_o, csr_mret_o;
  logic [31:0] csr_epc_o, csr_cause_o, csr_tval_o;
  logic        flush_early_o, flush_vld_o;
  logic [31:0] flush_addr_o;
  logic        flush_rdy_i, halt_req_i, resume_req_i, pipe_empty_i, halted_o;
  logic [31:0] dpc_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_flush_ctrl #(.XLEN(32), .NUM_IRQ(16), .RST_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .cmt_vld_i(cmt_vld_i), .cmt_rdy_o(cmt_rdy_o),
    .cmt_pc_i(cmt_pc_i), .cmt_npc_i(cmt_npc_i),
    .bjp_mispred_i(bjp_mispred_i), .bjp_fix_addr_i(bjp_fix_addr_i),
    .mret_i(mret_i), .excp_vld_i(excp_vld_i), .excp_cause_i(excp_cause_i),
    .excp_tval_i(excp_tval_i), .irq_pend_i(irq_pend_i), .irq_en_i(irq_en_i),
    .mstatus_mie_i(mstatus_mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .csr_trap_o(csr_trap_o), .csr_mret_o(csr_mret_o), .csr_epc_o(csr_epc_o),
    .csr_cause_o(csr_cause_o), .csr_tval_o(csr_tval_o),
    .flush_early_o(flush_early_o), .flush_vld_o(flush_vld_o),
    .flush_addr_o(flush_addr_o), .flush_rdy_i(flush_rdy_i),
    .halt_req_i(halt_req_i), .resume_req_i(resume_req_i),
    .pipe_empty_i(pipe_empty_i), .halted_o(halted_o), .dpc_o(dpc_o)
  );

  typedef struct {
    logic        vld;
    logic [31:0] pc, npc;
    logic        misp;
    logic [31:0] fix;
    logic        mret;
    logic        excp;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic [15:0] pend, en;
    logic        mie;
    logic [31:0] mtvec, mepc;
    logic        ev, trap, mrs;
    logic [31:0] epc, cause, etval, addr;
  } vec_t;

  localparam int NV = 12;
  vec_t v[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    cmt_vld_i = 1'b0; cmt_pc_i = '0; cmt_npc_i = '0;
    bjp_mispred_i = 1'b0; bjp_fix_addr_i = '0; mret_i = 1'b0;
    excp_vld_i = 1'b0; excp_cause_i = '0; excp_tval_i = '0;
    irq_pend_i = '0; irq_en_i = '0; mstatus_mie_i = 1'b0;
    mtvec_i = 32'h200; mepc_i = '0;
  endtask

  task automatic apply(input vec_t x);
    cmt_vld_i = x.vld; cmt_pc_i = x.pc; cmt_npc_i = x.npc;
    bjp_mispred_i = x.misp; bjp_fix_addr_i = x.fix; mret_i = x.mret;
    excp_vld_i = x.excp; excp_cause_i = x.ecause; excp_tval_i = x.tval;
    irq_pend_i = x.pend; irq_en_i = x.en; mstatus_mie_i = x.mie;
    mtvec_i = x.mtvec; mepc_i = x.mepc;
  endtask

  task automatic ack_flush();
    flush_rdy_i = 1'b1;
    @(posedge clk); #1;
    flush_rdy_i = 1'b0;
    chk("ack_flush_vld", {31'b0, flush_vld_o}, 32'h0);
    chk("ack_cmt_rdy", {31'b0, cmt_rdy_o}, 32'h1);
  endtask

  initial begin
    // vld pc npc misp fix mret excp ecause tval pend en mie mtvec mepc | ev trap mret epc cause tval addr
    v[0]  = '{1'b1, 32'h100, 32'h104, 1'b0, 32'h0, 1'b0, 1'b1, 5'd11, 32'h0, 16'h0, 16'h0, 1'b0, 32'h200, 32'h0,
              1'b1, 1'b1, 1'b0, 32'h100, 32'h0000000B, 32'h0, 32'h200};
    v[1]  = '{1'b1, 32'h3C, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 16'h0, 16'h0, 1'b0, 32'h200, 32'h0,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[2]  = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 16'h0880, 16'hFFFF, 1'b1, 32'h301, 32'h0,
              1'b1, 1'b1, 1'b0, 32'h40, 32'h8000000B, 32'h0, 32'h32C};
    v[3]  = '{1'b1, 32'h600, 32'h604, 1'b1, 32'h700, 1'b0, 1'b1, 5'd2, 32'hDEAD, 16'h0008, 16'h0008, 1'b1, 32'h401, 32'h0,
              1'b1, 1'b1, 1'b0, 32'h600, 32'h2, 32'hDEAD, 32'h400};
    v[4]  = '{1'b1, 32'h50, 32'h54, 1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 16'h0, 16'h0, 1'b0, 32'h200, 32'h1234,
              1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h1234};
    v[5]  = '{1'b1, 32'h80, 32'h84, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 16'h0C08, 16'h0408, 1'b1, 32'h1001, 32'h0,
              1'b1, 1'b1, 1'b0, 32'h84, 32'h80000003, 32'h0, 32'h100C};
    v[6]  = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 16'h0080, 16'h0080, 1'b0, 32'h200, 32'h0,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[7]  = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 16'h0025, 16'hFFFF, 1'b1, 32'h2001, 32'h0,
              1'b1, 1'b1, 1'b0, 32'h84, 32'h80000005, 32'h0, 32'h2014};
    v[8]  = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 16'h8080, 16'hFFFF, 1'b1, 32'h2000, 32'h0,
              1'b1, 1'b1, 1'b0, 32'h84, 32'h80000007, 32'h0, 32'h2000};
    v[9]  = '{1'b1, 32'h90, 32'h94, 1'b1, 32'h500, 1'b0, 1'b0, 5'd0, 32'h0, 16'h0, 16'h0, 1'b0, 32'h200, 32'h0,
              1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h500};
    v[10] = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 16'h8000, 16'h8000, 1'b1, 32'hFFFFFFF1, 32'h0,
              1'b1, 1'b1, 1'b0, 32'h94, 32'h8000000F, 32'h0, 32'h2C};
    v[11] = '{1'b1, 32'hA0, 32'hA4, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 16'h0800, 16'h0000, 1'b1, 32'h200, 32'h0,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};

    rst = 1'b1;
    clear_in();
    flush_rdy_i = 1'b0; halt_req_i = 1'b0; resume_req_i = 1'b0; pipe_empty_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmt_rdy", {31'b0, cmt_rdy_o}, 32'h0);
    chk("rst_flush_vld", {31'b0, flush_vld_o}, 32'h0);
    chk("rst_flush_addr", flush_addr_o, 32'h0);
    chk("rst_strobes", {29'b0, csr_trap_o, csr_mret_o, flush_early_o}, 32'h0);
    chk("rst_halted", {31'b0, halted_o}, 32'h0);
    chk("rst_dpc", dpc_o, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cmt_rdy", {31'b0, cmt_rdy_o}, 32'h1);

    for (int i = 0; i < NV; i++) begin
      apply(v[i]);
      #4;
      chk($sformatf("v%0d_early", i), {31'b0, flush_early_o}, {31'b0, v[i].ev});
      chk($sformatf("v%0d_trap", i), {31'b0, csr_trap_o}, {31'b0, v[i].trap});
      chk($sformatf("v%0d_mret", i), {31'b0, csr_mret_o}, {31'b0, v[i].mrs});
      chk($sformatf("v%0d_epc", i), csr_epc_o, v[i].epc);
      chk($sformatf("v%0d_cause", i), csr_cause_o, v[i].cause);
      chk($sformatf("v%0d_tval", i), csr_tval_o, v[i].etval);
      @(posedge clk); #1;
      clear_in();
      chk($sformatf("v%0d_flush_vld", i), {31'b0, flush_vld_o}, {31'b0, v[i].ev});
      if (v[i].ev) begin
        chk($sformatf("v%0d_flush_addr", i), flush_addr_o, v[i].addr);
        chk($sformatf("v%0d_stall", i), {31'b0, cmt_rdy_o}, 32'h0);
        ack_flush();
      end else begin
        chk($sformatf("v%0d_rdy", i), {31'b0, cmt_rdy_o}, 32'h1);
      end
    end

    // Mispredict with slow IFU; an interrupt raised during FLUSH waits for IDLE.
    cmt_vld_i = 1'b1; cmt_pc_i = 32'hC0; cmt_npc_i = 32'hC4;
    bjp_mispred_i = 1'b1; bjp_fix_addr_i = 32'h500;
    #4;
    chk("misp_early", {31'b0, flush_early_o}, 32'h1);
    @(posedge clk); #1;
    clear_in();
    irq_pend_i = 16'h0800; irq_en_i = 16'h0800; mstatus_mie_i = 1'b1; mtvec_i = 32'h200;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold%0d_vld", k), {31'b0, flush_vld_o}, 32'h1);
      chk($sformatf("hold%0d_addr", k), flush_addr_o, 32'h500);
      chk($sformatf("hold%0d_rdy", k), {31'b0, cmt_rdy_o}, 32'h0);
      chk($sformatf("hold%0d_no_trap", k), {31'b0, csr_trap_o}, 32'h0);
      flush_rdy_i = (k == 3);
      @(posedge clk); #1;
    end
    flush_rdy_i = 1'b0;
    chk("defer_vld_low", {31'b0, flush_vld_o}, 32'h0);
    chk("defer_trap", {31'b0, csr_trap_o}, 32'h1);
    chk("defer_cause", csr_cause_o, 32'h8000000B);
    chk("defer_epc", csr_epc_o, 32'hC4);
    @(posedge clk); #1;
    clear_in();
    chk("defer_flush_vld", {31'b0, flush_vld_o}, 32'h1);
    chk("defer_flush_addr", flush_addr_o, 32'h200);
    ack_flush();

    // Reset in the middle of a flush aborts it without a strobe.
    cmt_vld_i = 1'b1; cmt_pc_i = 32'hD0; cmt_npc_i = 32'hD4;
    bjp_mispred_i = 1'b1; bjp_fix_addr_i = 32'h700;
    @(posedge clk); #1;
    clear_in();
    chk("pre_rst_flush_vld", {31'b0, flush_vld_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_flush_vld", {31'b0, flush_vld_o}, 32'h0);
    chk("midrst_flush_addr", flush_addr_o, 32'h0);
    chk("midrst_trap", {31'b0, csr_trap_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_rdy", {31'b0, cmt_rdy_o}, 32'h1);
    chk("after_rst_flush_vld", {31'b0, flush_vld_o}, 32'h0);

`ifdef TRAP_FLUSH_DEBUG_EN
    // A mispredict beats the halt request, then the halt is retried.
    cmt_vld_i = 1'b1; cmt_pc_i = 32'hB0; cmt_npc_i = 32'hB4;
    bjp_mispred_i = 1'b1; bjp_fix_addr_i = 32'h600; halt_req_i = 1'b1;
    #4;
    chk("dbg_event_wins", {31'b0, flush_early_o}, 32'h1);
    @(posedge clk); #1;
    clear_in();
    chk("dbg_flush_addr", flush_addr_o, 32'h600);
    chk("dbg_not_halted", {31'b0, halted_o}, 32'h0);
    ack_flush();
    @(posedge clk); #1;
    halt_req_i = 1'b0;
    chk("drain_rdy", {31'b0, cmt_rdy_o}, 32'h0);
    chk("drain_halted", {31'b0, halted_o}, 32'h0);
    @(posedge clk); #1;
    chk("drain2_halted", {31'b0, halted_o}, 32'h0);
    pipe_empty_i = 1'b1;
    @(posedge clk); #1;
    pipe_empty_i = 1'b0;
    chk("halted", {31'b0, halted_o}, 32'h1);
    chk("halted_dpc", dpc_o, 32'hB4);
    chk("halted_rdy", {31'b0, cmt_rdy_o}, 32'h0);
    resume_req_i = 1'b1;
    @(posedge clk); #1;
    resume_req_i = 1'b0;
    chk("resume_halted", {31'b0, halted_o}, 32'h0);
    chk("resume_flush_vld", {31'b0, flush_vld_o}, 32'h1);
    chk("resume_flush_addr", flush_addr_o, 32'hB4);
    ack_flush();
`else
    halt_req_i = 1'b1; resume_req_i = 1'b1; pipe_empty_i = 1'b1;
    cmt_vld_i = 1'b1; cmt_pc_i = 32'hE0; cmt_npc_i = 32'hE4;
    #4;
    chk("nodbg_early", {31'b0, flush_early_o}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      cmt_vld_i = 1'b0;
      chk($sformatf("nodbg%0d_rdy", k), {31'b0, cmt_rdy_o}, 32'h1);
      chk($sformatf("nodbg%0d_halted", k), {31'b0, halted_o}, 32'h0);
      chk($sformatf("nodbg%0d_dpc", k), dpc_o, 32'h0);
      chk($sformatf("nodbg%0d_flush", k), {31'b0, flush_vld_o}, 32'h0);
    end
    halt_req_i = 1'b0; resume_req_i = 1'b0; pipe_empty_i = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
